// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the handshake constant buffer:
//   - buf_state_t       : occupancy state of the 2-entry skid storage
//   - DEFAULT_CNT_WIDTH : default width of the emitted-token counter
// -----------------------------------------------------------------------------
package handshake_pkg;

    localparam int DEFAULT_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no stored token
        ONE   = 2'd1,   // head entry holds a token
        FULL  = 2'd2    // head and tail entries hold tokens
    } buf_state_t;

endpackage : handshake_pkg

// File: rtl/handshake_skid2.sv
// -----------------------------------------------------------------------------
// handshake_skid2
// Two-entry skid buffer with a registered input ready.
//   Parameters: DATA_WIDTH - token width
//   Ports:
//     clk, rst   - rising-edge clock, asynchronous active-high reset
//     in_valid   - token offered on the input side
//     in_ready   - registered, high whenever storage is not FULL
//     in_data    - token value captured on an accept edge
//     out_data   - oldest stored token (head entry)
//     out_valid  - high whenever at least one token is stored
//     out_ready  - consumer accepts the head token
// -----------------------------------------------------------------------------
module handshake_skid2
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    buf_state_t            state_r;
    buf_state_t            state_s;
    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] head_s;
    logic [DATA_WIDTH-1:0] tail_r;
    logic [DATA_WIDTH-1:0] tail_s;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  accept_s;
    logic                  emit_s;

    // Next-state and storage update: head is always the oldest token.
    always_comb begin
        state_s  = state_r;
        head_s   = head_r;
        tail_s   = tail_r;
        // in_ready_r is already low in FULL, so ctrl tokens are ignored there.
        accept_s = in_valid && in_ready_r;
        emit_s   = out_valid_r && out_ready;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    head_s  = in_data;
                    state_s = ONE;
                end else begin
                    state_s = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && emit_s) begin
                    // Pass-through: replace the departing head, no bubble.
                    head_s  = in_data;
                    state_s = ONE;
                end else if (accept_s) begin
                    tail_s  = in_data;
                    state_s = FULL;
                end else if (emit_s) begin
                    state_s = EMPTY;
                end else begin
                    state_s = ONE;
                end
            end
            FULL: begin
                if (emit_s) begin
                    head_s  = tail_r;
                    state_s = ONE;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase
    end

    // State, storage and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            head_r      <= '0;
            tail_r      <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
            in_ready_r  <= (state_s != FULL);
            out_valid_r <= (state_s != EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = head_r;

endmodule : handshake_skid2

// File: rtl/handshake_constant_buf.sv
// -----------------------------------------------------------------------------
// handshake_constant_buf
// Emits one constant-valued token on outs for every trigger accepted on ctrl,
// buffered through a 2-entry skid stage, and counts consumed tokens.
//   Parameters: DATA_WIDTH, CONST_VALUE (reset/default constant), CNT_WIDTH
//   Ports:
//     clk, rst               - rising-edge clock, async active-high reset
//     ctrl_valid/ctrl_ready  - trigger handshake (ctrl_ready registered)
//     cfg_valid/cfg_data     - runtime constant update
//     outs/outs_valid/outs_ready - token output handshake
//     tok_count              - tokens consumed on outs, wraps
//   Build option: define HANDSHAKE_CONSTANT_BUF_CFG_EN to make the constant
//   runtime-updatable via cfg_valid/cfg_data; otherwise it is hard-wired to
//   CONST_VALUE and the cfg inputs are ignored.
// -----------------------------------------------------------------------------
module handshake_constant_buf
    import handshake_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0,
    parameter int                    CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic                  cfg_valid,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_WIDTH-1:0]  tok_count
);

    logic [DATA_WIDTH-1:0] value_s;
    logic [CNT_WIDTH-1:0]  tok_count_r;

`ifdef HANDSHAKE_CONSTANT_BUF_CFG_EN
    logic [DATA_WIDTH-1:0] value_r;

    // Constant register; an update on an accept edge only affects later tokens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= CONST_VALUE;
        end else if (cfg_valid) begin
            value_r <= cfg_data;
        end else begin
            value_r <= value_r;
        end
    end

    assign value_s = value_r;
`else
    logic unused_cfg_s;

    assign value_s      = CONST_VALUE;
    assign unused_cfg_s = ^{cfg_valid, cfg_data};
`endif

    handshake_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ctrl_valid),
        .in_ready  (ctrl_ready),
        .in_data   (value_s),
        .out_data  (outs),
        .out_valid (outs_valid),
        .out_ready (outs_ready)
    );

    // Consumed-token counter, wraps modulo 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_count_r <= '0;
        end else if (outs_valid && outs_ready) begin
            tok_count_r <= tok_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            tok_count_r <= tok_count_r;
        end
    end

    assign tok_count = tok_count_r;

endmodule : handshake_constant_buf

// File: tb/tb_handshake_constant_buf.sv
// -----------------------------------------------------------------------------
// tb_handshake_constant_buf
// Directed self-checking bench. Two instances share all inputs: dut uses a
// 16-bit counter, dut_w a 4-bit counter to observe wrap-around.
// -----------------------------------------------------------------------------
module tb_handshake_constant_buf;

    localparam int              DW   = 20;
    localparam logic [DW-1:0]   CVAL = 20'h5A785;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctrl_valid = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg_data = '0;
    logic          outs_ready = 1'b0;

    logic          ctrl_ready;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic [15:0]   tok_count;

    logic          ctrl_ready_w;
    logic [DW-1:0] outs_w;
    logic          outs_valid_w;
    logic [3:0]    tok_count_w;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_new;
    logic [DW-1:0] exp_late;

    handshake_constant_buf #(.DATA_WIDTH(DW), .CONST_VALUE(CVAL), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .outs(outs),
        .outs_valid(outs_valid), .outs_ready(outs_ready), .tok_count(tok_count)
    );

    handshake_constant_buf #(.DATA_WIDTH(DW), .CONST_VALUE(CVAL), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready_w),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .outs(outs_w),
        .outs_valid(outs_valid_w), .outs_ready(outs_ready), .tok_count(tok_count_w)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ctrl_valid = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        outs_ready = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        ctrl_valid = 1'b0;
        outs_ready = 1'b0;
        rst        = 1'b1;
        step();
        total++; if (ctrl_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ctrl_ready); end
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", outs_valid); end
        total++; if (outs !== 20'h00000) begin bad++; $display("FAIL rst_outs got=%h exp=00000", outs); end
        total++; if (tok_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", tok_count); end
        rst = 1'b0;
        step();
        total++; if (ctrl_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise got=%b exp=1", ctrl_ready); end
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_after got=%b exp=0", outs_valid); end
    endtask

    task automatic test_single();
        do_reset();
        outs_ready = 1'b1;
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        total++; if (outs_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", outs_valid); end
        total++; if (outs !== CVAL) begin bad++; $display("FAIL single_outs got=%h exp=%h", outs, CVAL); end
        total++; if (tok_count !== 16'd0) begin bad++; $display("FAIL single_cnt0 got=%0d exp=0", tok_count); end
        step();
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b exp=0", outs_valid); end
        total++; if (tok_count !== 16'd1) begin bad++; $display("FAIL single_cnt1 got=%0d exp=1", tok_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        outs_ready = 1'b0;
        ctrl_valid = 1'b1;
        step();
        total++; if (ctrl_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", ctrl_ready); end
        step();
        total++; if (ctrl_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", ctrl_ready); end
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (outs_valid !== 1'b1 || outs !== CVAL) begin bad++; $display("FAIL bp_stable got=%b/%h exp=1/%h", outs_valid, outs, CVAL); end
        end
        total++; if (ctrl_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_hold got=%b exp=0", ctrl_ready); end
        ctrl_valid = 1'b0;
        outs_ready = 1'b1;
        step();
        total++; if (ctrl_ready !== 1'b1 || outs_valid !== 1'b1) begin bad++; $display("FAIL bp_drain1 got=%b/%b exp=1/1", ctrl_ready, outs_valid); end
        step();
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL bp_drain2 got=%b exp=0", outs_valid); end
        total++; if (tok_count !== 16'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", tok_count); end
    endtask

    task automatic test_back_to_back();
        int bubbles;
        bubbles = 0;
        do_reset();
        outs_ready = 1'b1;
        ctrl_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (outs_valid !== 1'b1 || ctrl_ready !== 1'b1) bubbles++;
        end
        total++; if (bubbles != 0) begin bad++; $display("FAIL b2b_bubbles got=%0d exp=0", bubbles); end
        total++; if (tok_count !== 16'd99) begin bad++; $display("FAIL b2b_count got=%0d exp=99", tok_count); end
        total++; if (tok_count_w !== 4'd3) begin bad++; $display("FAIL b2b_count_w got=%0d exp=3", tok_count_w); end
        ctrl_valid = 1'b0;
        step();
        total++; if (tok_count !== 16'd100 || outs_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%0d/%b exp=100/0", tok_count, outs_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        outs_ready = 1'b1;
        ctrl_valid = 1'b1;
        for (int i = 0; i < 18; i++) step();
        ctrl_valid = 1'b0;
        total++; if (tok_count !== 16'd17) begin bad++; $display("FAIL wrap_count got=%0d exp=17", tok_count); end
        total++; if (tok_count_w !== 4'd1) begin bad++; $display("FAIL wrap_count_w got=%0d exp=1", tok_count_w); end
    endtask

    task automatic test_cfg();
`ifdef HANDSHAKE_CONSTANT_BUF_CFG_EN
        exp_new  = 20'h12345;
        exp_late = 20'h00ABC;
`else
        exp_new  = CVAL;
        exp_late = CVAL;
`endif
        do_reset();
        outs_ready = 1'b0;
        ctrl_valid = 1'b1;
        cfg_valid  = 1'b1;
        cfg_data   = 20'h12345;
        step();
        cfg_valid = 1'b0;
        total++; if (outs !== CVAL) begin bad++; $display("FAIL cfg_old_tok got=%h exp=%h", outs, CVAL); end
        step();
        ctrl_valid = 1'b0;
        cfg_valid  = 1'b1;
        cfg_data   = 20'h00ABC;
        step();
        cfg_valid  = 1'b0;
        outs_ready = 1'b1;
        total++; if (outs !== CVAL) begin bad++; $display("FAIL cfg_head_kept got=%h exp=%h", outs, CVAL); end
        step();
        total++; if (outs !== exp_new || outs_valid !== 1'b1) begin bad++; $display("FAIL cfg_new_tok got=%h exp=%h", outs, exp_new); end
        step();
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL cfg_drained got=%b exp=0", outs_valid); end
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        total++; if (outs !== exp_late) begin bad++; $display("FAIL cfg_late_tok got=%h exp=%h", outs, exp_late); end
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        outs_ready = 1'b1;
        ctrl_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        outs_ready = 1'b0;
        step();
        ctrl_valid = 1'b0;
        total++; if (tok_count !== 16'd2 || ctrl_ready !== 1'b0) begin bad++; $display("FAIL ar_pre got=%0d/%b exp=2/0", tok_count, ctrl_ready); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (outs_valid !== 1'b0 || tok_count !== 16'd0) begin bad++; $display("FAIL ar_immediate got=%b/%0d exp=0/0", outs_valid, tok_count); end
        total++; if (outs !== 20'h00000) begin bad++; $display("FAIL ar_outs got=%h exp=00000", outs); end
        #1;
        rst = 1'b0;
        outs_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (outs_valid !== 1'b0 || tok_count !== 16'd0) begin bad++; $display("FAIL ar_stale got=%b/%0d exp=0/0", outs_valid, tok_count); end
        end
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        total++; if (outs !== CVAL || outs_valid !== 1'b1) begin bad++; $display("FAIL ar_fresh got=%b/%h exp=1/%h", outs_valid, outs, CVAL); end
        step();
        total++; if (tok_count !== 16'd1) begin bad++; $display("FAIL ar_count got=%0d exp=1", tok_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_cfg();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_handshake_constant_buf

// File: doc/handshake_constant_buf.md
HANDSHAKE_CONSTANT_BUF -- requirements
Module: handshake_constant_buf

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32: width of the constant token.
REQ-002 The module SHALL have parameter CONST_VALUE, default 0 (DATA_WIDTH bits): reset/default constant.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 16: width of the emitted-token counter.
REQ-004 The module SHALL have port clk, input, 1 bit: the only clock; all state rising-edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port ctrl_valid, input, 1 bit: trigger token offered.
REQ-007 The module SHALL have port ctrl_ready, output, 1 bit: trigger accepted when high with ctrl_valid.
REQ-008 The module SHALL have port cfg_valid, input, 1 bit: runtime constant update strobe.
REQ-009 The module SHALL have port cfg_data, input, DATA_WIDTH bits: new constant value.
REQ-010 The module SHALL have port outs, output, DATA_WIDTH bits: constant token data.
REQ-011 The module SHALL have port outs_valid, output, 1 bit: token available.
REQ-012 The module SHALL have port outs_ready, input, 1 bit: consumer accepts token.
REQ-013 The module SHALL have port tok_count, output, CNT_WIDTH bits: number of tokens consumed on outs.

Function
REQ-014 The block SHALL be a 2-entry skid buffer; every accepted ctrl token SHALL yield exactly one outs token, in order.
REQ-015 The FSM SHALL have states EMPTY, ONE and FULL, holding 0, 1 and 2 stored tokens respectively.
REQ-016 ctrl_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from outs_ready.
REQ-017 outs_valid SHALL be 1 exactly when state != EMPTY; outs SHALL present the oldest stored token.
REQ-018 Latency SHALL be 1 cycle: a token accepted at edge N appears on outs/outs_valid after edge N.
REQ-019 Each stored token SHALL capture the current value register at its accept edge.
REQ-020 Accept and emit on the same edge in state ONE SHALL keep state ONE and load the new token; no bubble.
REQ-021 Accept without emit SHALL advance EMPTY->ONE or ONE->FULL; emit without accept SHALL go FULL->ONE (second entry promoted) or ONE->EMPTY.
REQ-022 In FULL, ctrl_valid SHALL be ignored; outs SHALL hold stable while outs_valid=1 and outs_ready=0.
REQ-023 tok_count SHALL increment on each outs_valid && outs_ready edge and SHALL wrap modulo 2^CNT_WIDTH.
REQ-024 cfg_valid on the same edge as an accept SHALL NOT affect that token; the new value applies from the next accept.
REQ-025 Tokens already stored SHALL NOT change when the value register is updated.

Reset
REQ-026 On rst: state EMPTY, ctrl_ready 0 (rising to 1 on the first edge after deassertion), outs_valid 0, outs 0, tok_count 0, value register CONST_VALUE.
REQ-027 Reset mid-operation SHALL discard all stored tokens immediately, regardless of clk.

Configuration
REQ-028 Macro HANDSHAKE_CONSTANT_BUF_CFG_EN defined: the value register SHALL load cfg_data whenever cfg_valid=1.
REQ-029 Macro undefined: cfg_valid/cfg_data SHALL be ignored, and the value SHALL be hard-wired to CONST_VALUE, with no value register inferred.

Structure
REQ-030 The shared package handshake_pkg SHALL hold the FSM state typedef (EMPTY/ONE/FULL) and the default CNT_WIDTH constant.
REQ-031 The 2-entry skid storage SHALL be one sub-module named handshake_skid2, instantiated once; constant and counter logic SHALL stay in the top.

Verification
REQ-032 Scenario 1: DATA_WIDTH=20, CONST_VALUE=0x5A785, outs_ready=1, one ctrl pulse -> outs=0x5A785 with outs_valid for exactly 1 cycle, 1 edge later; tok_count=1.
REQ-033 Scenario 2: outs_ready=0, ctrl_valid held for 4 cycles -> 2 accepts, then ctrl_ready=0; outs stable; on outs_ready=1 -> 2 tokens drained and ctrl_ready returns to 1.
REQ-034 Scenario 3: continuous ctrl_valid and outs_ready=1 -> one token per cycle at steady state, no bubbles; after 100 cycles tok_count=99.
REQ-035 Scenario 4 (CFG_EN): cfg_data=0x12345 with cfg_valid on an accept edge -> that token carries the old value, and the next token carries 0x12345; without the macro, all tokens carry CONST_VALUE.
REQ-036 Scenario 5: rst asserted asynchronously in FULL -> outs_valid=0 and tok_count=0 immediately; no stale token emitted after release.
REQ-037 Scenario 6: CNT_WIDTH=4, 17 tokens consumed -> tok_count=1 (wrap).
